// File: rtl/dsa_sign_mont_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dsa_pkg
// Purpose  : Shared types and constants for the dsa_sign_mont signer:
//            sequencer state enum, Montgomery operand-select enum and the
//            fixed multiplier latency.
// Revision : 1.0 - initial release
// ============================================================================
package dsa_pkg;

  // Cycles from multiplier issue to result-ready.
  localparam int unsigned MONT_LAT = 3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXP_P = 3'd1,
    RED_Q = 3'd2,
    INV_Q = 3'd3,
    SIGN  = 3'd4,
    FIN   = 3'd5
  } state_e;

  // Selects the operands/destination of the current Montgomery step.
  typedef enum logic [3:0] {
    OP_BASE = 4'd0,   // base  = mont(g or k, R^2)
    OP_INIT = 4'd1,   // acc   = mont(1, R^2)
    OP_SQR  = 4'd2,   // acc   = mont(acc, acc)
    OP_MUL  = 4'd3,   // acc   = mont(acc, base)
    OP_FROM = 4'd4,   // acc   = mont(acc, 1)
    OP_RM   = 4'd5,   // rm    = mont(v, R^2 mod q)
    OP_R    = 4'd6,   // rval  = mont(rm, 1)
    OP_XM   = 4'd7,   // tmp   = mont(x, R^2 mod q)
    OP_ZM   = 4'd8,   // zm    = mont(z, R^2 mod q)
    OP_XR   = 4'd9,   // tmp   = mont(xm, rm)
    OP_ADD  = 4'd10,  // tmp   = (tmp + zm) mod q, single cycle
    OP_TK   = 4'd11,  // tmp   = mont(tmp, kinv_m)
    OP_S    = 4'd12   // sval  = mont(tmp, 1)
  } op_e;

endpackage
`default_nettype wire

// File: rtl/dsa_sign_mont_mont_mul.sv
`default_nettype none
// ============================================================================
// Module   : mont_mul
// Purpose  : Pipelined Montgomery multiplier, res = a*b*R^-1 mod n, R=2^LEN,
//            fully reduced. go at cycle c gives rdy/res during cycle c+3.
// Ports    : clk, rst (async, active-high), go, a, b, n, n_prime (-n^-1 mod R)
//            -> res, rdy (single-cycle valid).
// Revision : 1.0 - initial release
// ============================================================================
module mont_mul
  import dsa_pkg::*;
#(
  parameter int LEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [LEN-1:0] a,
  input  logic [LEN-1:0] b,
  input  logic [LEN-1:0] n,
  input  logic [LEN-1:0] n_prime,
  output logic [LEN-1:0] res,
  output logic           rdy
);
  localparam int EW = 2 * LEN + 1;

  logic [LEN-1:0]    a_q, b_q, n1_q, np1_q, n2_q, np2_q, n3_q;
  logic [2*LEN-1:0]  t_q;
  logic [LEN:0]      u_q;
  logic [MONT_LAT-1:0] vld_q;

  logic [2*LEN-1:0]  w_prod;
  logic [LEN-1:0]    w_m;
  logic [EW-1:0]     w_sum;
  logic [LEN:0]      w_diff;

  assign w_prod = {{LEN{1'b0}}, a_q} * {{LEN{1'b0}}, b_q};
  // m = (t mod R) * n' mod R makes t + m*n divisible by R.
  assign w_m    = t_q[LEN-1:0] * np2_q;
  assign w_sum  = {1'b0, t_q} + ({{(LEN+1){1'b0}}, w_m} * {{(LEN+1){1'b0}}, n2_q});
  assign w_diff = u_q - {1'b0, n3_q};
  // u < 2n, so one conditional subtract fully reduces.
  assign res    = (u_q >= {1'b0, n3_q}) ? LEN'(w_diff) : LEN'(u_q);
  assign rdy    = vld_q[MONT_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      n1_q  <= '0;
      np1_q <= '0;
      n2_q  <= '0;
      np2_q <= '0;
      n3_q  <= '0;
      t_q   <= '0;
      u_q   <= '0;
      vld_q <= '0;
    end else begin
      if (go) begin
        a_q   <= a;
        b_q   <= b;
        n1_q  <= n;
        np1_q <= n_prime;
      end
      t_q   <= w_prod;
      n2_q  <= n1_q;
      np2_q <= np1_q;
      u_q   <= (LEN+1)'(w_sum >> LEN);
      n3_q  <= n2_q;
      vld_q <= {vld_q[MONT_LAT-2:0], go};
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsa_sign_mont.sv
`default_nettype none
// ============================================================================
// Module   : dsa_sign_mont
// Purpose  : DSA signer: r = (g^k mod p) mod q, s = k^-1 (z + x r) mod q,
//            all products through one shared mont_mul instance.
// Ports    : clk, rst (async, active-high), start; p q g x k z, p_prime,
//            q_prime, r2_mod_p, r2_mod_q (LEN each) -> busy, r, s, done, err.
// Macro    : DSA_SIGN_CT_EN - every exponent step issues the multiply (result
//            discarded on 0 bits), making latency independent of k and q.
// Revision : 1.0 - initial release
// ============================================================================
module dsa_sign_mont
  import dsa_pkg::*;
#(
  parameter int LEN = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [LEN-1:0] p,
  input  logic [LEN-1:0] q,
  input  logic [LEN-1:0] g,
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] k,
  input  logic [LEN-1:0] z,
  input  logic [LEN-1:0] p_prime,
  input  logic [LEN-1:0] q_prime,
  input  logic [LEN-1:0] r2_mod_p,
  input  logic [LEN-1:0] r2_mod_q,
  output logic           busy,
  output logic [LEN-1:0] r,
  output logic [LEN-1:0] s,
  output logic           done,
  output logic           err
);
`ifdef DSA_SIGN_CT_EN
  localparam bit CT_MODE = 1'b1;
`else
  localparam bit CT_MODE = 1'b0;
`endif
  localparam int             IW      = $clog2(LEN);
  localparam logic [IW-1:0]  IDX_MAX = IW'(LEN - 1);
  localparam logic [LEN-1:0] ONE     = LEN'(1);

  state_e         state_q, state_d;
  op_e            op_q, op_d;
  logic           wait_q, wait_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [LEN-1:0] base_q, base_d, acc_q, acc_d, rm_q, rm_d, rval_q, rval_d;
  logic [LEN-1:0] tmp_q, tmp_d, zm_q, zm_d, sval_q, sval_d, r_q, r_d, s_q, s_d;
  logic           done_q, done_d, err_q, err_d;
  logic [LEN-1:0] p_q, q_q, g_q, x_q, k_q, z_q, pp_q, qp_q, r2p_q, r2q_q;

  logic           w_accept, w_go, w_rdy, w_step, w_ebit;
  logic [LEN-1:0] w_mm_a, w_mm_b, w_res, w_n, w_np, w_r2, w_exp, w_add;
  logic [LEN:0]   w_sum1, w_sub;

  assign busy = (state_q != IDLE);
  assign r    = r_q;
  assign s    = s_q;
  assign done = done_q;
  assign err  = err_q;

  // EXP_P works modulo p; every later phase works modulo q.
  assign w_n   = (state_q == EXP_P) ? p_q   : q_q;
  assign w_np  = (state_q == EXP_P) ? pp_q  : qp_q;
  assign w_r2  = (state_q == EXP_P) ? r2p_q : r2q_q;
  assign w_exp = (state_q == EXP_P) ? k_q   : (q_q - LEN'(2));
  assign w_ebit = w_exp[idx_q];

  // Modular add on LEN+1 bits: both operands < q, so one subtract suffices.
  assign w_sum1 = {1'b0, tmp_q} + {1'b0, zm_q};
  assign w_sub  = w_sum1 - {1'b0, q_q};
  assign w_add  = (w_sum1 >= {1'b0, q_q}) ? LEN'(w_sub) : LEN'(w_sum1);

  mont_mul #(.LEN(LEN)) u_mont (
    .clk     (clk),
    .rst     (rst),
    .go      (w_go),
    .a       (w_mm_a),
    .b       (w_mm_b),
    .n       (w_n),
    .n_prime (w_np),
    .res     (w_res),
    .rdy     (w_rdy)
  );

  always_comb begin
    w_mm_a = acc_q;
    w_mm_b = acc_q;
    case (op_q)
      OP_BASE: begin w_mm_a = (state_q == EXP_P) ? g_q : k_q; w_mm_b = w_r2; end
      OP_INIT: begin w_mm_a = ONE;   w_mm_b = w_r2;   end
      OP_MUL:  begin                 w_mm_b = base_q; end
      OP_FROM: begin                 w_mm_b = ONE;    end
      OP_RM:   begin                 w_mm_b = w_r2;   end
      OP_R:    begin w_mm_a = rm_q;  w_mm_b = ONE;    end
      OP_XM:   begin w_mm_a = x_q;   w_mm_b = w_r2;   end
      OP_ZM:   begin w_mm_a = z_q;   w_mm_b = w_r2;   end
      OP_XR:   begin w_mm_a = tmp_q; w_mm_b = rm_q;   end
      OP_TK:   begin w_mm_a = tmp_q; w_mm_b = acc_q;  end
      OP_S:    begin w_mm_a = tmp_q; w_mm_b = ONE;    end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;  op_d   = op_q;   wait_d = wait_q;  idx_d  = idx_q;
    base_d  = base_q;   acc_d  = acc_q;  rm_d   = rm_q;    rval_d = rval_q;
    tmp_d   = tmp_q;    zm_d   = zm_q;   sval_d = sval_q;
    r_d     = r_q;      s_d    = s_q;    err_d  = err_q;   done_d = 1'b0;
    w_accept = 1'b0;    w_go   = 1'b0;   w_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          state_d  = EXP_P;
          op_d     = OP_BASE;
          wait_d   = 1'b0;
        end
      end
      EXP_P, RED_Q, INV_Q, SIGN: begin
        if (op_q == OP_ADD) begin
          tmp_d = w_add;
          op_d  = OP_TK;
        end else if (!wait_q) begin
          w_go   = 1'b1;
          wait_d = 1'b1;
        end else if (w_rdy) begin
          wait_d = 1'b0;
          case (op_q)
            OP_BASE: begin base_d = w_res; op_d = OP_INIT; end
            OP_INIT: begin acc_d = w_res; op_d = OP_SQR; idx_d = IDX_MAX; end
            OP_SQR: begin
              acc_d = w_res;
              if (CT_MODE || w_ebit) op_d = OP_MUL;
              else                   w_step = 1'b1;
            end
            // In constant-time mode a 0 bit still multiplies; keep old acc.
            OP_MUL: begin
              if (w_ebit) acc_d = w_res;
              w_step = 1'b1;
            end
            OP_FROM: begin acc_d = w_res; state_d = RED_Q; op_d = OP_RM; end
            OP_RM:   begin rm_d = w_res; op_d = OP_R; end
            OP_R:    begin rval_d = w_res; state_d = INV_Q; op_d = OP_BASE; end
            OP_XM:   begin tmp_d = w_res; op_d = OP_ZM; end
            OP_ZM:   begin zm_d = w_res; op_d = OP_XR; end
            OP_XR:   begin tmp_d = w_res; op_d = OP_ADD; end
            OP_TK:   begin tmp_d = w_res; op_d = OP_S; end
            OP_S:    begin sval_d = w_res; state_d = FIN; end
            default: ;
          endcase
        end
        // Advance the MSB-first exponent scan after a bit is finished.
        if (w_step) begin
          if (idx_q == '0) begin
            if (state_q == EXP_P) begin
              op_d = OP_FROM;
            end else begin
              state_d = SIGN;
              op_d    = OP_XM;
            end
          end else begin
            idx_d = idx_q - IW'(1);
            op_d  = OP_SQR;
          end
        end
      end
      FIN: begin
        r_d     = rval_q;
        s_d     = sval_q;
        err_d   = (rval_q == '0) || (sval_q == '0);
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;  op_q   <= OP_BASE;  wait_q <= 1'b0;  idx_q  <= '0;
      base_q  <= '0;    acc_q  <= '0;       rm_q   <= '0;    rval_q <= '0;
      tmp_q   <= '0;    zm_q   <= '0;       sval_q <= '0;
      r_q     <= '0;    s_q    <= '0;       err_q  <= 1'b0;  done_q <= 1'b0;
    end else begin
      state_q <= state_d; op_q   <= op_d;     wait_q <= wait_d;  idx_q  <= idx_d;
      base_q  <= base_d;  acc_q  <= acc_d;    rm_q   <= rm_d;    rval_q <= rval_d;
      tmp_q   <= tmp_d;   zm_q   <= zm_d;     sval_q <= sval_d;
      r_q     <= r_d;     s_q    <= s_d;      err_q  <= err_d;   done_q <= done_d;
    end
  end

  // Operands are captured at accept so the host may change them afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q  <= '0; q_q  <= '0; g_q   <= '0; x_q   <= '0; k_q <= '0; z_q <= '0;
      pp_q <= '0; qp_q <= '0; r2p_q <= '0; r2q_q <= '0;
    end else if (w_accept) begin
      p_q  <= p;       q_q  <= q;       g_q   <= g;        x_q   <= x;
      k_q  <= k;       z_q  <= z;       pp_q  <= p_prime;  qp_q  <= q_prime;
      r2p_q <= r2_mod_p; r2q_q <= r2_mod_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsa_sign_mont.sv
`default_nettype none
// ============================================================================
// Module   : tb_dsa_sign_mont
// Purpose  : Self-checking bench for dsa_sign_mont (LEN=64 and LEN=32
//            instances): table of known and random signing vectors, plus
//            mid-operation start and mid-operation reset sequences.
// Macro    : DSA_SIGN_CT_EN selects the constant-time latency expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dsa_sign_mont;

  typedef struct {
    bit          w32;
    logic [63:0] p, q, g, x, k, z, pp, qp, r2p, r2q;
    logic [63:0] r_e, s_e;
    bit          err_e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start64, start32;
  logic [63:0] p, q, g, x, k, z, pp, qp, r2p, r2q;
  logic [31:0] pp32, qp32, r2p32, r2q32;
  logic        busy64, done64, err64, busy32, done32, err32;
  logic [63:0] r64, s64;
  logic [31:0] r32, s32;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  dsa_sign_mont #(.LEN(64)) dut64 (
    .clk(clk), .rst(rst), .start(start64),
    .p(p), .q(q), .g(g), .x(x), .k(k), .z(z),
    .p_prime(pp), .q_prime(qp), .r2_mod_p(r2p), .r2_mod_q(r2q),
    .busy(busy64), .r(r64), .s(s64), .done(done64), .err(err64)
  );

  dsa_sign_mont #(.LEN(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32),
    .p(p[31:0]), .q(q[31:0]), .g(g[31:0]), .x(x[31:0]), .k(k[31:0]), .z(z[31:0]),
    .p_prime(pp32), .q_prime(qp32), .r2_mod_p(r2p32), .r2_mod_q(r2q32),
    .busy(busy32), .r(r32), .s(s32), .done(done32), .err(err32)
  );

  // ---------------- reference model (plain modular arithmetic) ----------
  function automatic logic [63:0] mulmod(input logic [63:0] a, b, m);
    logic [127:0] t;
    t = ({64'd0, a} * {64'd0, b}) % {64'd0, m};
    return t[63:0];
  endfunction

  function automatic logic [63:0] powmod(input logic [63:0] b, e, m);
    logic [63:0] res, base, ee;
    res = 64'd1 % m; base = b % m; ee = e;
    while (ee != 64'd0) begin
      if (ee[0]) res = mulmod(res, base, m);
      base = mulmod(base, base, m);
      ee = ee >> 1;
    end
    return res;
  endfunction

  function automatic logic [63:0] invmod(input logic [63:0] a, m);
    longint t0, t1, r0, r1, qq, tmp;
    t0 = 0; t1 = 1; r0 = longint'(m); r1 = longint'(a);
    while (r1 != 0) begin
      qq = r0 / r1;
      tmp = r0 - qq * r1; r0 = r1; t0 = t0; r1 = tmp;
      tmp = t0 - qq * t1; t0 = t1; t1 = tmp;
    end
    if (t0 < 0) t0 = t0 + longint'(m);
    return 64'(t0);
  endfunction

  function automatic logic [63:0] nprime(input logic [63:0] n, input int len);
    logic [63:0] inv;
    inv = n;
    for (int i = 0; i < 6; i++) inv = inv * (64'd2 - n * inv);
    inv = -inv;
    return (len == 32) ? {32'd0, inv[31:0]} : inv;
  endfunction

  function automatic logic [63:0] r2mod(input logic [63:0] n, input int len);
    logic [128:0] big;
    big = (129'd1 << (2 * len)) % {65'd0, n};
    return big[63:0];
  endfunction

  function automatic vec_t rand_vec();
    logic [63:0] primes [7];
    vec_t v;
    logic [63:0] rr, ki;
    primes = '{64'd101, 64'd65521, 64'd998244353, 64'd1000000007,
               64'd2147483647, 64'd4294967291, 64'd2305843009213693951};
    v.w32 = 1'b0;
    v.q   = primes[$urandom_range(0, 6)];
    v.p   = {1'b0, 31'($urandom), 32'($urandom)} | 64'd1;
    v.g   = {$urandom, $urandom} % v.p;
    v.x   = {$urandom, $urandom} % v.q;
    v.k   = 64'd1 + ({$urandom, $urandom} % (v.q - 64'd1));
    v.z   = {$urandom, $urandom};
    v.pp  = nprime(v.p, 64);  v.qp  = nprime(v.q, 64);
    v.r2p = r2mod(v.p, 64);   v.r2q = r2mod(v.q, 64);
    rr    = powmod(v.g, v.k, v.p) % v.q;
    ki    = invmod(v.k, v.q);
    v.r_e = rr;
    v.s_e = mulmod(ki, ((v.z % v.q) + mulmod(v.x, rr, v.q)) % v.q, v.q);
    v.err_e = (v.r_e == 64'd0) || (v.s_e == 64'd0);
    return v;
  endfunction

  function automatic int exp_lat(input vec_t v);
    int len;
    len = v.w32 ? 32 : 64;
`ifdef DSA_SIGN_CT_EN
    return 4 * (4 * len + 12) + 2;
`else
    return 4 * (2 * len + 12 + $countones(v.k) + $countones(v.q - 64'd2)) + 2;
`endif
  endfunction

  function automatic vec_t mk(input bit w32, input logic [63:0] p_, q_, g_, x_, k_, z_,
                              pp_, r2p_, qp_, r2q_, re, se, input bit ee);
    vec_t v;
    v.w32 = w32; v.p = p_; v.q = q_; v.g = g_; v.x = x_; v.k = k_; v.z = z_;
    v.pp = pp_; v.r2p = r2p_; v.qp = qp_; v.r2q = r2q_;
    v.r_e = re; v.s_e = se; v.err_e = ee;
    return v;
  endfunction

  // ---------------- checking helpers -----------------------------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  function automatic logic [63:0] o_r(input bit w32);
    return w32 ? {32'd0, r32} : r64;
  endfunction
  function automatic logic [63:0] o_s(input bit w32);
    return w32 ? {32'd0, s32} : s64;
  endfunction
  function automatic logic o_done(input bit w32);
    return w32 ? done32 : done64;
  endfunction
  function automatic logic o_busy(input bit w32);
    return w32 ? busy32 : busy64;
  endfunction
  function automatic logic o_err(input bit w32);
    return w32 ? err32 : err64;
  endfunction

  task automatic drive(input vec_t v);
    p = v.p; q = v.q; g = v.g; x = v.x; k = v.k; z = v.z;
    pp = v.pp; qp = v.qp; r2p = v.r2p; r2q = v.r2q;
    pp32 = v.pp[31:0]; qp32 = v.qp[31:0]; r2p32 = v.r2p[31:0]; r2q32 = v.r2q[31:0];
  endtask

  task automatic scramble();
    p = {$urandom, $urandom}; q = {$urandom, $urandom}; g = {$urandom, $urandom};
    x = {$urandom, $urandom}; k = {$urandom, $urandom}; z = {$urandom, $urandom};
  endtask

  task automatic run_vec(input vec_t v, input bit glitch, input string tag, output int lat);
    int lim;
    lim = exp_lat(v) + 200;
    @(negedge clk);
    drive(v);
    if (v.w32) start32 = 1'b1; else start64 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0; start64 = 1'b0;
    scramble();
    chk({tag, "_busy_acc"}, 64'(o_busy(v.w32)), 64'd1);
    lat = 0;
    while (!o_done(v.w32) && lat < lim) begin
      if (glitch && lat == 100) begin
        drive(v); k = 64'd1; start64 = 1'b1;
      end else begin
        start64 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start64 = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'(exp_lat(v)));
    chk({tag, "_r"}, o_r(v.w32), v.r_e);
    chk({tag, "_s"}, o_s(v.w32), v.s_e);
    chk({tag, "_err"}, 64'(o_err(v.w32)), 64'(v.err_e));
    chk({tag, "_busy_done"}, 64'(o_busy(v.w32)), 64'd0);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, 64'(o_done(v.w32)), 64'd0);
    chk({tag, "_r_hold"}, o_r(v.w32), v.r_e);
  endtask

  // ---------------- stimulus --------------------------------------------
  initial begin
    int lat, lat0, lat1;
    rst = 1'b1; start64 = 1'b0; start32 = 1'b0;
    lat0 = 0; lat1 = 0;
    p = '0; q = '0; g = '0; x = '0; k = '0; z = '0;
    pp = '0; qp = '0; r2p = '0; r2q = '0;
    pp32 = '0; qp32 = '0; r2p32 = '0; r2q32 = '0;

    tbl.push_back(mk(1'b0, 64'd7879, 64'd101, 64'd170, 64'd75, 64'd50, 64'd42,
                     64'h256e1d0c1e8abd09, 64'hd48, 64'hc5b3f5dc83cd4e93, 64'h50,
                     64'd94, 64'd57, 1'b0));
    tbl.push_back(mk(1'b0, 64'd7879, 64'd101, 64'd170, 64'd75, 64'd1, 64'd42,
                     64'h256e1d0c1e8abd09, 64'hd48, 64'hc5b3f5dc83cd4e93, 64'h50,
                     64'd69, 64'd66, 1'b0));
    tbl.push_back(mk(1'b1, 64'd7879, 64'd101, 64'd170, 64'd75, 64'd50, 64'd42,
                     64'h1e8abd09, 64'h3a9, 64'h83cd4e93, 64'h4f,
                     64'd94, 64'd57, 1'b0));
    for (int i = 0; i < 6; i++) tbl.push_back(rand_vec());
    tbl.push_back(mk(1'b0, 64'd7879, 64'd101, 64'd170, 64'd75, 64'd50, 64'd20,
                     64'h256e1d0c1e8abd09, 64'hd48, 64'hc5b3f5dc83cd4e93, 64'h50,
                     64'd94, 64'd0, 1'b1));

    repeat (3) @(posedge clk);
    #1;
    chk("rst_r", r64, 64'd0);
    chk("rst_s", s64, 64'd0);
    chk("rst_done", 64'(done64), 64'd0);
    chk("rst_busy", 64'(busy64), 64'd0);
    chk("rst_err", 64'(err64), 64'd0);
    chk("rst_busy32", 64'(busy32), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      run_vec(tbl[i], 1'b0, $sformatf("v%0d", i), lat);
      if (i == 0) lat0 = lat;
      if (i == 1) lat1 = lat;
    end
`ifdef DSA_SIGN_CT_EN
    chk("lat_k50_vs_k1_equal", 64'(lat0 == lat1), 64'd1);
`else
    chk("lat_k50_vs_k1_equal", 64'(lat0 == lat1), 64'd0);
`endif

    // Reset in the middle of EXP_P; previous outputs (r=94, err=1) must clear.
    @(negedge clk);
    drive(tbl[0]);
    start64 = 1'b1;
    @(posedge clk); #1;
    start64 = 1'b0;
    repeat (50) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_r", r64, 64'd0);
    chk("midrst_s", s64, 64'd0);
    chk("midrst_busy", 64'(busy64), 64'd0);
    chk("midrst_done", 64'(done64), 64'd0);
    chk("midrst_err", 64'(err64), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_vec(tbl[0], 1'b0, "after_rst", lat);

    // A second start with a different k while busy must be ignored.
    run_vec(tbl[0], 1'b1, "glitch", lat);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
